// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: N-way set-associative write-back cache controller.
// Handles zero-wait hits, dirty-victim writeback, invalid-first victim
// choice and per-set tree pseudo-LRU replacement.
// Optional performance counters are built when CACHE_PERF_COUNTERS_EN is defined;
// otherwise the counter outputs read zero and no counter flops exist.
module cache_ctrl_assoc #(
  parameter  int WAYS     = 4,
  parameter  int SET_BITS = 3,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [SET_BITS-1:0] set_idx,
  input  logic [WAYS-1:0]     way_hit,
  input  logic [WAYS-1:0]     way_valid,
  input  logic [WAYS-1:0]     way_dirty,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [WAYS-1:0]     tag_load,
  output logic [WAYS-1:0]     valid_load,
  output logic [WAYS-1:0]     dirty_load,
  output logic [WAYS-1:0]     data_we,
  output logic                dirty_in,
  output logic [1:0]          data_sel,
  output logic                addr_sel,
  output logic [WAY_BITS-1:0] victim_way,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
);

  localparam int NUM_SETS = 2 ** SET_BITS;
  localparam int NODES    = WAYS - 1;

  typedef enum logic [1:0] {
    ST_CHECK     = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [WAY_BITS-1:0] victim_r;
  logic [NODES-1:0]    plru_r [NUM_SETS];

  logic                request_s;
  logic                hit_any_s;
  logic [WAY_BITS-1:0] hit_way_s;
  logic [WAY_BITS-1:0] inv_way_s;
  logic [WAY_BITS-1:0] plru_way_s;
  logic [WAY_BITS-1:0] victim_sel_s;
  logic                victim_dirty_s;
  logic [NODES-1:0]    plru_cur_s;
  logic [NODES-1:0]    plru_upd_s;
  logic                plru_we_s;
  logic                victim_we_s;
  logic [WAYS-1:0]     hit_oh_s;
  logic [WAYS-1:0]     victim_oh_s;

  assign request_s   = mem_read | mem_write;
  assign hit_any_s   = |way_hit;
  assign plru_cur_s  = plru_r[set_idx];
  assign hit_oh_s    = {{(WAYS-1){1'b0}}, 1'b1} << hit_way_s;
  assign victim_oh_s = {{(WAYS-1){1'b0}}, 1'b1} << victim_r;
  assign victim_way  = victim_r;

  // Lowest-index hitting way and lowest-index invalid way (priority encoders)
  always_comb begin
    hit_way_s = '0;
    inv_way_s = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      hit_way_s = way_hit[i]    ? WAY_BITS'(i) : hit_way_s;
      inv_way_s = !way_valid[i] ? WAY_BITS'(i) : inv_way_s;
    end
  end

  // Walk the PLRU tree from the root to find the pseudo-LRU way of this set
  always_comb begin
    logic [WAY_BITS-1:0] node;
    logic                dir;
    plru_way_s = '0;
    node       = '0;
    dir        = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir        = plru_cur_s[node];
      plru_way_s = (plru_way_s << 1) | {{(WAY_BITS-1){1'b0}}, dir};
      node       = (node << 1) + {{(WAY_BITS-1){1'b0}}, 1'b1} + {{(WAY_BITS-1){1'b0}}, dir};
    end
  end

  // Point every node on the hit way's path away from that way
  always_comb begin
    logic [WAY_BITS-1:0] node;
    logic [WAY_BITS-1:0] path;
    logic                dir;
    plru_upd_s = plru_cur_s;
    node       = '0;
    path       = hit_way_s;
    dir        = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir              = path[WAY_BITS-1];
      plru_upd_s[node] = ~dir;
      path             = path << 1;
      node             = (node << 1) + {{(WAY_BITS-1){1'b0}}, 1'b1} + {{(WAY_BITS-1){1'b0}}, dir};
    end
  end

  // Victim: prefer an invalid way, otherwise the pseudo-LRU way
  always_comb begin
    if (&way_valid) begin
      victim_sel_s = plru_way_s;
    end else begin
      victim_sel_s = inv_way_s;
    end
    victim_dirty_s = way_valid[victim_sel_s] & way_dirty[victim_sel_s];
  end

  // Next-state and array/memory control decode; everything idles while rst is high
  always_comb begin
    state_nx_s  = state_r;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    tag_load    = '0;
    valid_load  = '0;
    dirty_load  = '0;
    data_we     = '0;
    dirty_in    = 1'b0;
    data_sel    = 2'b11;
    addr_sel    = 1'b0;
    plru_we_s   = 1'b0;
    victim_we_s = 1'b0;
    if (!rst) begin
      case (state_r)
        ST_CHECK: begin
          if (request_s && hit_any_s) begin
            mem_resp  = 1'b1;
            plru_we_s = 1'b1;
            if (mem_write) begin
              data_we    = hit_oh_s;
              data_sel   = 2'b01;
              dirty_load = hit_oh_s;
              dirty_in   = 1'b1;
            end else begin
              data_sel   = 2'b11;
            end
          end else if (request_s) begin
            victim_we_s = 1'b1;
            if (victim_dirty_s) begin
              state_nx_s = ST_WRITEBACK;
            end else begin
              state_nx_s = ST_FILL;
            end
          end else begin
            state_nx_s = ST_CHECK;
          end
        end
        ST_WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel   = 1'b1;
          if (pmem_resp) begin
            state_nx_s = ST_FILL;
          end else begin
            state_nx_s = ST_WRITEBACK;
          end
        end
        ST_FILL: begin
          pmem_read = 1'b1;
          data_sel  = 2'b00;
          if (pmem_resp) begin
            data_we    = victim_oh_s;
            tag_load   = victim_oh_s;
            valid_load = victim_oh_s;
            dirty_load = victim_oh_s;
            dirty_in   = 1'b0;
            state_nx_s = ST_CHECK;
          end else begin
            state_nx_s = ST_FILL;
          end
        end
        default: begin
          state_nx_s = ST_CHECK;
        end
      endcase
    end else begin
      state_nx_s = ST_CHECK;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CHECK;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Victim way captured on the miss cycle, held through writeback and fill
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_r <= '0;
    end else if (victim_we_s) begin
      victim_r <= victim_sel_s;
    end
  end

  // Per-set PLRU tree bits, updated on every hit response
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_r[s] <= '0;
      end
    end else if (plru_we_s) begin
      plru_r[set_idx] <= plru_upd_s;
    end
  end

`ifdef CACHE_PERF_COUNTERS_EN
  logic        retry_r;
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;
  logic [31:0] wb_cnt_r;
  logic        miss_evt_s;
  logic        wb_evt_s;
  logic        fill_done_s;

  assign miss_evt_s  = !rst && (state_r == ST_CHECK) && request_s && !hit_any_s;
  assign wb_evt_s    = miss_evt_s && victim_dirty_s;
  assign fill_done_s = !rst && (state_r == ST_FILL) && pmem_resp;
  assign hit_count   = hit_cnt_r;
  assign miss_count  = miss_cnt_r;
  assign wb_count    = wb_cnt_r;

  // Retry flag marks the post-fill hit so it is not counted; counters saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_r    <= 1'b0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
      wb_cnt_r   <= 32'd0;
    end else begin
      if (fill_done_s) begin
        retry_r <= 1'b1;
      end else if (mem_resp) begin
        retry_r <= 1'b0;
      end
      if (mem_resp && !retry_r && (hit_cnt_r != 32'hFFFF_FFFF)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_evt_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
      if (wb_evt_s && (wb_cnt_r != 32'hFFFF_FFFF)) begin
        wb_cnt_r <= wb_cnt_r + 32'd1;
      end
    end
  end
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
  assign wb_count   = 32'd0;
`endif

endmodule
